// File: rtl/inv_check_pkg.sv
// Shared types and helpers for the inverse-by-negation signed-greater sweep checker.
package inv_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Largest positive signed value of a w-bit vector; it has no strictly greater signed value.
  function automatic int unsigned smax(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic logic sgt(input logic signed [31:0] a, input logic signed [31:0] b);
    return a > b;
  endfunction

endpackage

// File: rtl/bvneg_sgt_eval.sv
// Combinational check: ok when -x (two's complement) is signed-greater than t, or t is SMAX.
module bvneg_sgt_eval
  import inv_check_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_t,
  input  logic [WIDTH-1:0] i_x,
  output logic             o_ok
);

  logic [WIDTH-1:0]  w_neg;
  logic signed [31:0] w_neg_ext;
  logic signed [31:0] w_t_ext;
  logic              w_is_smax;

  assign w_neg     = ~i_x + {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_neg_ext = {{(32-WIDTH){w_neg[WIDTH-1]}}, w_neg};
  assign w_t_ext   = {{(32-WIDTH){i_t[WIDTH-1]}}, i_t};
  assign w_is_smax = (i_t == WIDTH'(smax(WIDTH)));
  assign o_ok      = sgt(w_neg_ext, w_t_ext) || w_is_smax;

endmodule

// File: rtl/inv_bvsgt_neg_sweep_checker.sv
// Sweeps every t, counts witness failures, holds results until handshake.
// Optional first-failure capture enabled by macro INV_CHECK_FIRSTFAIL_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start, cand_t = 0
// ST_SWEEP | one t evaluated per cycle, t = 0 .. all-ones
// ST_DONE  | results valid, held until done_ready
module inv_bvsgt_neg_sweep_checker
  import inv_check_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] cand_t,
  input  logic [WIDTH-1:0] cand_x,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             pass,
  output logic [WIDTH:0]   fail_count,
  output logic [WIDTH-1:0] first_fail_t,
  output logic [WIDTH-1:0] first_fail_x
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_t;
  logic [WIDTH:0]   r_fail_count;
  logic             w_ok;
  logic             w_accept;
  logic             w_sweeping;
  logic             w_eval_fail;
  logic             w_last;

  assign w_accept    = (r_state == ST_IDLE) && start;
  assign w_sweeping  = (r_state == ST_SWEEP);
  assign w_eval_fail = w_sweeping && !w_ok;
  assign w_last      = (r_t == {WIDTH{1'b1}});

  bvneg_sgt_eval #(.WIDTH(WIDTH)) u_eval (
    .i_t  (cand_t),
    .i_x  (cand_x),
    .o_ok (w_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start)      w_state_nxt = ST_SWEEP;
      ST_SWEEP: if (w_last)     w_state_nxt = ST_DONE;
      ST_DONE:  if (done_ready) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // t wraps to 0 on the final edge, but that value is never evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t          <= '0;
      r_fail_count <= '0;
    end else if (w_accept) begin
      r_t          <= '0;
      r_fail_count <= '0;
    end else if (w_sweeping) begin
      r_t <= r_t + {{(WIDTH-1){1'b0}}, 1'b1};
      if (w_eval_fail) r_fail_count <= r_fail_count + {{WIDTH{1'b0}}, 1'b1};
    end
  end

`ifdef INV_CHECK_FIRSTFAIL_EN
  logic             r_ff_seen;
  logic [WIDTH-1:0] r_ff_t;
  logic [WIDTH-1:0] r_ff_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff_seen <= 1'b0;
      r_ff_t    <= '0;
      r_ff_x    <= '0;
    end else if (w_accept) begin
      r_ff_seen <= 1'b0;
      r_ff_t    <= '0;
      r_ff_x    <= '0;
    end else if (w_eval_fail && !r_ff_seen) begin
      r_ff_seen <= 1'b1;
      r_ff_t    <= cand_t;
      r_ff_x    <= cand_x;
    end
  end

  assign first_fail_t = r_ff_t;
  assign first_fail_x = r_ff_x;
`else
  assign first_fail_t = '0;
  assign first_fail_x = '0;
`endif

  assign busy       = (r_state == ST_SWEEP) || (r_state == ST_DONE);
  assign done_valid = (r_state == ST_DONE);
  assign cand_t     = w_sweeping ? r_t : '0;
  assign fail_count = r_fail_count;
  assign pass       = (r_fail_count == '0);

endmodule

// File: doc/inv_bvsgt_neg_sweep_checker.md
INV_BVSGT_NEG_SWEEP_CHECKER -- requirements
Module: inv_bvsgt_neg_sweep_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the operand bit width of t and x.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit, a sweep request, sampled only in IDLE.
REQ-005 SHALL have port busy, output, 1 bit, high in SWEEP and DONE.
REQ-006 SHALL have port cand_t, output, WIDTH bits, the current t driven to the external combinational witness function.
REQ-007 SHALL have port cand_x, input, WIDTH bits, the witness x returned combinationally for cand_t in the same cycle.
REQ-008 SHALL have port done_valid, output, 1 bit, result valid.
REQ-009 SHALL have port done_ready, input, 1 bit, result accepted by the consumer.
REQ-010 SHALL have port pass, output, 1 bit, high when fail_count is 0, valid while done_valid is high.
REQ-011 SHALL have port fail_count, output, WIDTH+1 bits, the number of violating t values.
REQ-012 SHALL have ports first_fail_t and first_fail_x, outputs, WIDTH bits each, the first violating pair (see REQ-024).

Function
REQ-013 SHALL implement the FSM IDLE -> SWEEP -> DONE -> IDLE.
REQ-014 SHALL move IDLE->SWEEP on the edge where start=1, set t register to 0, and clear fail_count and the first-fail registers.
REQ-015 SHALL evaluate one t per cycle in SWEEP: neg = (~cand_x + 1) mod 2^WIDTH; ok = ($signed(neg) > $signed(cand_t)) OR (cand_t == SMAX), where SMAX = 2^(WIDTH-1)-1 (no inverse exists, so t = SMAX is exempt).
REQ-016 SHALL increment fail_count on the same edge when ok=0 (saturation impossible, since the maximum is 2^WIDTH-1).
REQ-017 SHALL increment t by 1 each SWEEP cycle; on the edge evaluating t = all-ones, it SHALL go to DONE, with no t wrap evaluated.
REQ-018 SHALL assert done_valid only in DONE, with constant results, the sweep taking exactly 2^WIDTH cycles after start acceptance (16 for WIDTH=4).
REQ-019 SHALL go DONE->IDLE on the edge where done_ready=1, and SHALL hold done_valid and the results indefinitely while done_ready=0.
REQ-020 SHALL ignore start in SWEEP and DONE, including a start coincident with the done_ready handshake; a new sweep needs start in IDLE.
REQ-021 SHALL drive cand_t = 0 in IDLE and DONE.

Reset
REQ-022 SHALL, on rst_n low at any time including mid-sweep, immediately enter IDLE and set busy=0, done_valid=0, cand_t=0, fail_count=0, first_fail_t=0, first_fail_x=0; pass SHALL read 1 but be qualified by done_valid.
REQ-023 SHALL take no partial-sweep results across reset.

Configuration
REQ-024 SHALL use macro INV_CHECK_FIRSTFAIL_EN: when defined, capture cand_t/cand_x at the first ok=0 of a sweep and hold them until the next start; when undefined, no capture registers exist and first_fail_t/first_fail_x SHALL be tied to 0.

Structure
REQ-025 SHALL place the state enum type, the SMAX function of WIDTH, and the signed greater-than helper in shared package inv_check_pkg.
REQ-026 SHALL use one sub-module, bvneg_sgt_eval (combinational: t, x -> ok), instantiated once; the FSM, counters, and capture logic reside in the top module.

Verification
REQ-027 SHALL cover: cand_x = 4'b1001 constant, start pulse -> done_valid after 16 cycles, pass=1, fail_count=0.
REQ-028 SHALL cover: cand_x = 0 constant -> fail_count=7 (t=0..6), pass=0, first_fail_t=0, first_fail_x=0 with the macro, both 0 without it.
REQ-029 SHALL cover: cand_x = 4'b1000 constant -> fail_count=15 (all t except 7), first_fail_t=0, first_fail_x=8.
REQ-030 SHALL cover: done_ready low for 5 cycles in DONE, then high -> results stable throughout, IDLE next edge; a start pulse in that cycle is ignored.
REQ-031 SHALL cover: rst_n low at t=9 during a failing sweep -> all outputs reset at once, and a fresh start yields a full 16-cycle sweep with correct counts.
REQ-032 SHALL cover: start held high throughout a sweep -> exactly one sweep; a new sweep begins only after the DONE handshake returns to IDLE.
